// File: rtl/kyber_pkg.sv
// Shared ML-KEM constants and the modulus-check FSM state type.
package kyber_pkg;

    localparam int KYBER_Q   = 3329;
    localparam int KYBER_N   = 256;
    localparam int KYBER_K   = 3;
    localparam int EK_BYTES  = 1184;
    localparam int T_BYTES   = 1152;

    // Scan FSM: idle, one group of three bytes per cycle, one-cycle completion.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } ek_chk_state_t;

endpackage : kyber_pkg

// File: rtl/ek_coeff_unpack.sv
// Unpacks one byte triple into two 12-bit coefficients and flags each one
// that is not a canonical residue (value >= Q).
module ek_coeff_unpack #(
    parameter int Q = 3329
) (
    input  logic [7:0] b0_i,
    input  logic [7:0] b1_i,
    input  logic [7:0] b2_i,
    output logic       c0_bad_o,
    output logic       c1_bad_o
);

    localparam logic [11:0] Q12 = 12'(Q);

    logic [11:0] c0;
    logic [11:0] c1;

    // Little-endian 12-bit packing: c0 takes the low nibble of b1, c1 the high nibble.
    always_comb begin
        c0       = {b1_i[3:0], b0_i};
        c1       = {b2_i, b1_i[7:4]};
        c0_bad_o = (c0 >= Q12);
        c1_bad_o = (c1 >= Q12);
    end

endmodule : ek_coeff_unpack

// File: rtl/ek_modulus_check.sv
// Scans the t-hat portion of an ML-KEM encapsulation key, one byte triple
// per cycle over a fixed 384-cycle window, and reports whether every
// coefficient is below Q together with the lowest failing coefficient index.
module ek_modulus_check
    import kyber_pkg::*;
#(
    parameter int EK_BYTES = kyber_pkg::EK_BYTES,
    parameter int T_BYTES  = kyber_pkg::T_BYTES,
    parameter int Q        = kyber_pkg::KYBER_Q
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] ek [EK_BYTES-1:0],
    output logic       busy,
    output logic       done,
    output logic       ek_valid,
    output logic [9:0] first_bad
);

    localparam logic [8:0] G_LAST = 9'(T_BYTES / 3 - 1);

    ek_chk_state_t state_q, state_d;
    logic [8:0]    g_q, g_d;
    logic          err_q, err_d;
    logic [9:0]    first_bad_q, first_bad_d;
    logic          ek_valid_q, ek_valid_d;

    logic [10:0]   base;
    logic          c0_bad;
    logic          c1_bad;
    logic          last_group;

    // Byte address of the current group is 3*g; ek itself is never copied.
    always_comb begin
        base       = {1'b0, g_q, 1'b0} + {2'b00, g_q};
        last_group = (g_q == G_LAST);
    end

    ek_coeff_unpack #(
        .Q (Q)
    ) u_unpack (
        .b0_i     (ek[base]),
        .b1_i     (ek[base + 11'd1]),
        .b2_i     (ek[base + 11'd2]),
        .c0_bad_o (c0_bad),
        .c1_bad_o (c1_bad)
    );

    // State register; reset overrides everything, including a pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only looked at in IDLE, the scan never exits early.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHECK;
            ST_CHECK: if (last_group) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        busy = (state_q == ST_CHECK);
        done = (state_q == ST_DONE);
    end

    // Scan datapath next-state: group counter, sticky error flag, first failing index, verdict.
    always_comb begin
        g_d         = g_q;
        err_d       = err_q;
        first_bad_d = first_bad_q;
        ek_valid_d  = ek_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    g_d         = '0;
                    err_d       = 1'b0;
                    first_bad_d = '0;
                    ek_valid_d  = 1'b0;
                end
            end
            ST_CHECK: begin
                // Counter saturates at the last group rather than wrapping.
                if (!last_group) g_d = g_q + 9'd1;
                if (!err_q && (c0_bad || c1_bad)) begin
                    first_bad_d = {g_q, ~c0_bad};
                end
                err_d = err_q | c0_bad | c1_bad;
                // Verdict is settled with the last group so it is already visible in the done cycle.
                if (last_group) ek_valid_d = ~(err_q | c0_bad | c1_bad);
            end
            default: ;
        endcase
    end

    // Datapath registers; verdict and index hold until the next accepted start or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_q         <= '0;
            err_q       <= 1'b0;
            first_bad_q <= '0;
            ek_valid_q  <= 1'b0;
        end else begin
            g_q         <= g_d;
            err_q       <= err_d;
            first_bad_q <= first_bad_d;
            ek_valid_q  <= ek_valid_d;
        end
    end

    assign ek_valid  = ek_valid_q;
    assign first_bad = first_bad_q;

endmodule : ek_modulus_check

// File: tb/tb_ek_modulus_check.sv
// Self-checking bench for ek_modulus_check: directed keys plus randomized keys
// checked against a bit-stream reference model of the 12-bit coefficient encoding.
module tb_ek_modulus_check;

    localparam int EK_BYTES = 1184;
    localparam int T_BYTES  = 1152;
    localparam int Q        = 3329;
    localparam int NCOEF    = T_BYTES * 8 / 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] ek [EK_BYTES-1:0];
    logic       busy;
    logic       done;
    logic       ek_valid;
    logic [9:0] first_bad;

    int vectors    = 0;
    int miscompares = 0;

    ek_modulus_check #(
        .EK_BYTES (EK_BYTES),
        .T_BYTES  (T_BYTES),
        .Q        (Q)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ek        (ek),
        .busy      (busy),
        .done      (done),
        .ek_valid  (ek_valid),
        .first_bad (first_bad)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: treat t-hat as a little-endian bit stream of 12-bit coefficients.
    function automatic void model(output bit v, output int fb);
        v  = 1'b1;
        fb = 0;
        for (int i = 0; i < NCOEF; i++) begin
            int bp  = 12 * i;
            int b   = bp / 8;
            int val = ((((int'(ek[b + 1]) << 8) | int'(ek[b])) >> (bp % 8)) & 32'hFFF);
            if (val >= Q && v) begin
                v  = 1'b0;
                fb = i;
            end
        end
    endfunction

    function automatic void set_coef(input int idx, input int val);
        for (int j = 0; j < 12; j++) begin
            int bit_pos = 12 * idx + j;
            ek[bit_pos / 8][bit_pos % 8] = val[j];
        end
    endfunction

    function automatic void fill(input logic [7:0] t_val, input logic [7:0] rho_val);
        for (int i = 0; i < EK_BYTES; i++) ek[i] = (i < T_BYTES) ? t_val : rho_val;
    endfunction

    // Start a scan at the next edge (E) and watch until well past the done cycle.
    // Sampling at negedge k observes the state left by edge E+k, so the done
    // cycle (the one closed by edge E+385) is seen at k = 384.
    task automatic scan(input string tag, input int s1, input int s2);
        bit ev;
        int efb;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_k   = -1;
        model(ev, efb);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/cleared_valid"}, 32'(ek_valid), 0);
        chk({tag, "/cleared_first_bad"}, 32'(first_bad), 0);
        for (int k = 0; k < 395; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_k = k;
                chk({tag, "/valid_at_done"}, 32'(ek_valid), 32'(ev));
                chk({tag, "/first_bad_at_done"}, 32'(first_bad), 32'(efb));
            end
            start = (k == s1 || k == s2);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "/busy_cycles"}, busy_cnt, 384);
        chk({tag, "/done_pulses"}, done_cnt, 1);
        chk({tag, "/done_cycle"}, done_k, 384);
        chk({tag, "/valid_held"}, 32'(ek_valid), 32'(ev));
        chk({tag, "/first_bad_held"}, 32'(first_bad), 32'(efb));
    endtask

    initial begin
        int done_seen;
        rst   = 1'b1;
        start = 1'b0;
        fill(8'h00, 8'h00);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("reset/busy", 32'(busy), 0);
        chk("reset/done", 32'(done), 0);
        chk("reset/valid", 32'(ek_valid), 0);
        chk("reset/first_bad", 32'(first_bad), 0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        fill(8'h00, 8'h00);
        scan("all_zero", -1, -1);

        for (int i = 0; i < T_BYTES; i++) ek[i] = (i % 3 == 0) ? 8'h00 : ((i % 3 == 1) ? 8'h0D : 8'hD0);
        scan("all_3328", -1, -1);

        fill(8'h00, 8'h00);
        ek[1150] = 8'h10;
        ek[1151] = 8'hD0;
        scan("coef767_is_q", -1, -1);

        fill(8'hFF, 8'hFF);
        scan("all_ff", -1, -1);

        fill(8'h00, 8'hFF);
        scan("rho_ff", -1, -1);

        // Restarts mid-scan and on the done cycle must be ignored.
        fill(8'h00, 8'h00);
        set_coef(301, 4000);
        set_coef(500, 3329);
        scan("restart_ignored", 10, 384);

        // Reset at E+200 aborts the scan; a latched first_bad must be cleared.
        fill(8'h00, 8'h00);
        set_coef(10, 4095);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 199; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort/busy", 32'(busy), 0);
        chk("abort/done", 32'(done), 0);
        chk("abort/valid", 32'(ek_valid), 0);
        chk("abort/first_bad", 32'(first_bad), 0);
        done_seen = 0;
        for (int k = 0; k < 400; k++) begin
            if (done || busy) done_seen++;
            @(negedge clk);
        end
        chk("abort/no_activity", done_seen, 0);
        scan("after_abort", -1, -1);

        // Randomized keys: raw random bytes, then mostly-valid keys with injected bad coefficients.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < EK_BYTES; i++) ek[i] = 8'($urandom_range(255, 0));
            scan($sformatf("rand_bytes%0d", r), -1, -1);
        end
        for (int r = 0; r < 5; r++) begin
            int nbad = r % 3;
            for (int i = 0; i < NCOEF; i++) set_coef(i, int'($urandom_range(Q - 1, 0)));
            for (int i = T_BYTES; i < EK_BYTES; i++) ek[i] = 8'($urandom_range(255, 0));
            for (int b = 0; b < nbad; b++) set_coef(int'($urandom_range(NCOEF - 1, 0)), int'($urandom_range(4095, Q)));
            scan($sformatf("rand_coef%0d", r), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ek_modulus_check
